bsg_manycore_store_responder: RTL

BSG_MANYCORE_STORE_RESPONDER -- requirements
Module: bsg_manycore_store_responder

---
 rtl/bsg_manycore_resp_pkg.sv | 45 ++++
 rtl/bsg_manycore_ret_fifo.sv | 45 ++++
 rtl/bsg_manycore_store_responder.sv | 107 ++++++++++
 3 files changed

// File: rtl/bsg_manycore_resp_pkg.sv
// bsg_manycore_resp_pkg: op encodings, packet layouts and width helpers for the store responder.
package bsg_manycore_resp_pkg;
    localparam int op_width_gp = 2;
    localparam int ret_pad_width_gp = 5;
    localparam int def_x_cord_width_gp = 4;
    localparam int def_y_cord_width_gp = 4;
    localparam int def_data_width_gp = 32;
    localparam int def_addr_width_gp = 32;

    typedef enum logic [op_width_gp-1:0] {
        e_op_store    = 2'd0,
        e_op_freeze   = 2'd1,
        e_op_unfreeze = 2'd2
    } op_e;

    // Reference layouts at the default widths; the top rebuilds them from its parameters.
    typedef struct packed {
        logic [op_width_gp-1:0]           op;
        logic [def_data_width_gp/8-1:0]   mask;
        logic [def_data_width_gp-1:0]     data;
        logic [def_addr_width_gp-1:0]     addr;
        logic [def_y_cord_width_gp-1:0]   from_y;
        logic [def_x_cord_width_gp-1:0]   from_x;
        logic [def_y_cord_width_gp-1:0]   y;
        logic [def_x_cord_width_gp-1:0]   x;
    } req_packet_s;

    typedef struct packed {
        logic [ret_pad_width_gp-1:0]      pad;
        logic [def_y_cord_width_gp-1:0]   from_y;
        logic [def_x_cord_width_gp-1:0]   from_x;
    } ret_packet_s;

    function automatic int req_packet_width(int x_w, int y_w, int d_w, int a_w);
        return op_width_gp + d_w / 8 + d_w + a_w + 2 * (x_w + y_w);
    endfunction

    function automatic int ret_packet_width(int x_w, int y_w);
        return ret_pad_width_gp + x_w + y_w;
    endfunction

    function automatic logic is_known_op(logic [op_width_gp-1:0] op);
        return op == e_op_store || op == e_op_freeze || op == e_op_unfreeze;
    endfunction
endpackage

// File: rtl/bsg_manycore_ret_fifo.sv
// bsg_manycore_ret_fifo: 1r1w return-packet queue with registered storage and an occupancy count.
module bsg_manycore_ret_fifo #(
    parameter int width_p = 13,
    parameter int els_p = 4,
    localparam int count_width_lp = $clog2(els_p + 1),
    localparam int ptr_width_lp = $clog2(els_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      v_i,
    input  logic [width_p-1:0]        data_i,
    input  logic                      yumi_i,
    output logic                      v_o,
    output logic [width_p-1:0]        data_o,
    output logic [count_width_lp-1:0] count_o
);
    logic [width_p-1:0] mem [els_p];
    logic [ptr_width_lp-1:0] rptr, wptr;
    logic enq, deq;

    function automatic logic [ptr_width_lp-1:0] next_ptr(logic [ptr_width_lp-1:0] p);
        return p == ptr_width_lp'(els_p - 1) ? '0 : p + 1'b1;
    endfunction

    assign v_o = count_o != '0;
    assign data_o = mem[rptr];
    assign deq = yumi_i & v_o;
    assign enq = v_i & (count_o != count_width_lp'(els_p) | deq);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr <= '0;
            wptr <= '0;
            count_o <= '0;
        end else begin
            if (enq) wptr <= next_ptr(wptr);
            if (deq) rptr <= next_ptr(rptr);
            count_o <= count_o + count_width_lp'(enq) - count_width_lp'(deq);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem[wptr] <= data_i;
    end
endmodule

// File: rtl/bsg_manycore_store_responder.sv
// bsg_manycore_store_responder: buffers one request, issues stores, queues returns, tracks freeze.
// Optional BSG_MANYCORE_RET_SELF_SUPPRESS_EN drops returns for stores originating from this tile.
module bsg_manycore_store_responder
    import bsg_manycore_resp_pkg::*;
#(
    parameter int x_cord_width_p = 4,
    parameter int y_cord_width_p = 4,
    parameter int data_width_p = 32,
    parameter int addr_width_p = 32,
    parameter int ret_els_p = 4,
    localparam int packet_width_lp = req_packet_width(x_cord_width_p, y_cord_width_p, data_width_p, addr_width_p),
    localparam int ret_packet_width_lp = ret_packet_width(x_cord_width_p, y_cord_width_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           v_i,
    input  logic [packet_width_lp-1:0]     data_i,
    output logic                           ready_o,
    output logic                           mem_v_o,
    output logic [addr_width_p-1:0]        mem_addr_o,
    output logic [data_width_p-1:0]        mem_data_o,
    output logic [data_width_p/8-1:0]      mem_mask_o,
    input  logic                           mem_yumi_i,
    output logic                           ret_v_o,
    output logic [ret_packet_width_lp-1:0] ret_data_o,
    input  logic                           ret_ready_i,
    input  logic [x_cord_width_p-1:0]      my_x_i,
    input  logic [y_cord_width_p-1:0]      my_y_i,
    output logic                           freeze_o,
    output logic                           err_o
);
    localparam int count_width_lp = $clog2(ret_els_p + 1);

    typedef struct packed {
        logic [op_width_gp-1:0]      op;
        logic [data_width_p/8-1:0]   mask;
        logic [data_width_p-1:0]     data;
        logic [addr_width_p-1:0]     addr;
        logic [y_cord_width_p-1:0]   from_y;
        logic [x_cord_width_p-1:0]   from_x;
        logic [y_cord_width_p-1:0]   y;
        logic [x_cord_width_p-1:0]   x;
    } req_s;

    typedef enum logic [1:0] {e_idle, e_decode, e_issue} state_e;

    state_e state;
    req_s req, req_in;
    logic [count_width_lp-1:0] ret_count;
    logic [ret_packet_width_lp-1:0] ret_pkt;
    logic commit, enq, unused;

    assign req_in = req_s'(data_i);
    assign ready_o = state == e_idle;
    // Slot check uses the registered count so a store never relies on a same-cycle dequeue.
    assign mem_v_o = state == e_issue && ret_count != count_width_lp'(ret_els_p);
    assign commit = mem_v_o & mem_yumi_i;
    assign mem_addr_o = req.addr;
    assign mem_data_o = req.data;
    assign mem_mask_o = req.mask;
    assign ret_pkt = {{ret_pad_width_gp{1'b0}}, req.from_y, req.from_x};
    assign unused = ^{req.y, req.x, my_x_i, my_y_i};

`ifdef BSG_MANYCORE_RET_SELF_SUPPRESS_EN
    assign enq = commit & ~(req.from_x == my_x_i && req.from_y == my_y_i);
`else
    assign enq = commit;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= e_idle;
            req <= '0;
            freeze_o <= 1'b1;
            err_o <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                e_idle: if (v_i) begin
                    req <= req_in;
                    err_o <= !is_known_op(req_in.op);
                    state <= e_decode;
                end
                e_decode: begin
                    state <= req.op == e_op_store ? e_issue : e_idle;
                    freeze_o <= req.op == e_op_freeze ? 1'b1 : req.op == e_op_unfreeze ? 1'b0 : freeze_o;
                end
                e_issue: if (commit) state <= e_idle;
                default: state <= e_idle;
            endcase
        end
    end

    bsg_manycore_ret_fifo #(
        .width_p(ret_packet_width_lp),
        .els_p(ret_els_p)
    ) ret_fifo (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .v_i(enq),
        .data_i(ret_pkt),
        .yumi_i(ret_ready_i),
        .v_o(ret_v_o),
        .data_o(ret_data_o),
        .count_o(ret_count)
    );
endmodule
